// File: rtl/dma_request_arbiter_pkg.sv
// Shared types and constants for the 8237A DMA request arbiter.
// Optional software-request support is enabled with DMA_SOFTWARE_REQUEST_EN.
package dma_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned MODE_W = 2 * NUM_CH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        DEMAND       = 2'b00,
        SINGLE       = 2'b01,
        BLOCK        = 2'b10,
        CASCADE_RSVD = 2'b11
    } dma_mode_t;

    // Resolver result: winning channel plus a flag that any channel was eligible
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            valid;
    } grant_t;

    // Extract one channel's mode; the reserved encoding behaves as single mode
    function automatic dma_mode_t chan_mode(input logic [MODE_W-1:0] mode_bus,
                                            input logic [CH_W-1:0]   ch);
        logic [1:0] w_bits;
        w_bits = mode_bus[{ch, 1'b0} +: 2];
        return (w_bits == 2'b11) ? SINGLE : dma_mode_t'(w_bits);
    endfunction

endpackage

// File: rtl/dma_request_arbiter_if.sv
// Device/processor/timing-engine signal bundle for the DMA request arbiter.
// SwReq/SwPending exist only when DMA_SOFTWARE_REQUEST_EN is defined.
interface dma_request_arbiter_if;
    import dma_pkg::*;

    logic [NUM_CH-1:0] Dreq;
    logic [NUM_CH-1:0] Mask;
    logic [MODE_W-1:0] Mode;
    logic              RotatePriority;
    logic              HLDA;
    logic              ByteDone;
    logic              TC;
    logic              HRQ;
    logic [NUM_CH-1:0] Dack;
    logic [CH_W-1:0]   ActiveCh;
    logic              ServiceValid;
    logic [NUM_CH-1:0] Status;
`ifdef DMA_SOFTWARE_REQUEST_EN
    logic [NUM_CH-1:0] SwReq;
    logic [NUM_CH-1:0] SwPending;

    // Environment side: devices, processor and timing engine
    modport master (
        output Dreq, Mask, Mode, RotatePriority, HLDA, ByteDone, TC, SwReq,
        input  HRQ, Dack, ActiveCh, ServiceValid, Status, SwPending
    );

    // Arbiter side
    modport slave (
        input  Dreq, Mask, Mode, RotatePriority, HLDA, ByteDone, TC, SwReq,
        output HRQ, Dack, ActiveCh, ServiceValid, Status, SwPending
    );
`else
    // Environment side: devices, processor and timing engine
    modport master (
        output Dreq, Mask, Mode, RotatePriority, HLDA, ByteDone, TC,
        input  HRQ, Dack, ActiveCh, ServiceValid, Status
    );

    // Arbiter side
    modport slave (
        input  Dreq, Mask, Mode, RotatePriority, HLDA, ByteDone, TC,
        output HRQ, Dack, ActiveCh, ServiceValid, Status
    );
`endif

endinterface

// File: rtl/dma_request_arbiter_resolver.sv
// Combinational channel priority resolver, fixed or rotating from a pointer.
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] i_eligible,
    input  logic [CH_W-1:0]   i_pointer,
    input  logic              i_rotate,
    output grant_t            o_grant_c
);

    logic [CH_W-1:0] w_start;
    logic [CH_W-1:0] w_idx;

    // Scan from lowest priority to highest so the highest-priority hit wins last
    always_comb begin
        w_start   = i_rotate ? i_pointer : '0;
        w_idx     = '0;
        o_grant_c = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            w_idx = w_start + CH_W'(k);
            if (i_eligible[w_idx]) begin
                o_grant_c.ch    = w_idx;
                o_grant_c.valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_request_arbiter.sv
// DMA request arbiter: Dreq collection, HRQ/HLDA handshake and one-hot Dack grant.
// Defining DMA_SOFTWARE_REQUEST_EN adds sticky software requests serviced in block mode.
module dma_request_arbiter
    import dma_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    dma_request_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_REQ     = 2'(REQ);
    localparam logic [1:0] S_SERVICE = 2'(SERVICE);
    localparam logic [1:0] S_RELEASE = 2'(RELEASE);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_hrq;
    logic              w_hrq_nxt;
    logic [NUM_CH-1:0] r_dack;
    logic [NUM_CH-1:0] w_dack_nxt;
    logic [CH_W-1:0]   r_active;
    logic [CH_W-1:0]   w_active_nxt;
    logic              r_svc;
    logic              w_svc_nxt;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   w_ptr_nxt;
    logic [NUM_CH-1:0] r_status;

    logic [NUM_CH-1:0] w_elig_hw;
    logic [NUM_CH-1:0] w_elig;
    grant_t            w_grant;
    dma_mode_t         w_mode;
    logic              w_exit;

    assign w_elig_hw = bus.Dreq & ~bus.Mask;

`ifdef DMA_SOFTWARE_REQUEST_EN
    logic [NUM_CH-1:0] r_sw_pending;
    logic [NUM_CH-1:0] w_sw_clr;

    assign w_elig = w_elig_hw | r_sw_pending;

    // Terminal count on the serviced channel retires its software request
    always_comb begin
        w_sw_clr = '0;
        if (r_state == S_SERVICE && bus.TC) begin
            w_sw_clr = NUM_CH'(1) << r_active;
        end
    end

    // Sticky software request bits; a new pulse wins over a same-cycle clear
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sw_pending <= '0;
        end else begin
            r_sw_pending <= (r_sw_pending & ~w_sw_clr) | bus.SwReq;
        end
    end

    assign bus.SwPending = r_sw_pending;
`else
    assign w_elig = w_elig_hw;
`endif

    dma_priority_resolver u_resolver (
        .i_eligible (w_elig),
        .i_pointer  (r_ptr),
        .i_rotate   (bus.RotatePriority),
        .o_grant_c  (w_grant)
    );

    // Effective mode of the active channel and the service exit condition
    always_comb begin
        w_mode = chan_mode(bus.Mode, r_active);
`ifdef DMA_SOFTWARE_REQUEST_EN
        if (r_sw_pending[r_active]) begin
            w_mode = BLOCK;
        end
`endif
        w_exit = 1'b0;
        if (!bus.HLDA) begin
            w_exit = 1'b1;
        end else if (bus.TC) begin
            w_exit = 1'b1;
        end else begin
            case (w_mode)
                SINGLE, CASCADE_RSVD: w_exit = bus.ByteDone;
                DEMAND:               w_exit = bus.ByteDone & ~bus.Dreq[r_active];
                default:              w_exit = 1'b0;
            endcase
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_hrq_nxt    = r_hrq;
        w_dack_nxt   = r_dack;
        w_active_nxt = r_active;
        w_svc_nxt    = r_svc;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            S_IDLE: begin
                w_hrq_nxt  = 1'b0;
                w_dack_nxt = '0;
                w_svc_nxt  = 1'b0;
                if (|w_elig) begin
                    w_state_nxt = S_REQ;
                    w_hrq_nxt   = 1'b1;
                end
            end
            S_REQ: begin
                w_hrq_nxt = 1'b1;
                if (bus.HLDA) begin
                    if (w_grant.valid) begin
                        w_state_nxt  = S_SERVICE;
                        w_active_nxt = w_grant.ch;
                        w_dack_nxt   = NUM_CH'(1) << w_grant.ch;
                        w_svc_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                        w_hrq_nxt   = 1'b0;
                    end
                end
            end
            S_SERVICE: begin
                if (w_exit) begin
                    w_state_nxt = S_RELEASE;
                    w_hrq_nxt   = 1'b0;
                    w_dack_nxt  = '0;
                    w_svc_nxt   = 1'b0;
                    w_ptr_nxt   = r_active + CH_W'(1);
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_hrq_nxt   = 1'b0;
                w_dack_nxt  = '0;
                w_svc_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hrq_nxt   = 1'b0;
                w_dack_nxt  = '0;
                w_svc_nxt   = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_hrq    <= 1'b0;
            r_dack   <= '0;
            r_active <= '0;
            r_svc    <= 1'b0;
            r_ptr    <= '0;
            r_status <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hrq    <= w_hrq_nxt;
            r_dack   <= w_dack_nxt;
            r_active <= w_active_nxt;
            r_svc    <= w_svc_nxt;
            r_ptr    <= w_ptr_nxt;
            r_status <= w_elig_hw;
        end
    end

    assign bus.HRQ          = r_hrq;
    assign bus.Dack         = r_dack;
    assign bus.ActiveCh     = r_active;
    assign bus.ServiceValid = r_svc;
    assign bus.Status       = r_status;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed self-checking bench for dma_request_arbiter.
module tb_dma_request_arbiter;
    import dma_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rot_exp [4];

    always #5 clk = ~clk;

    dma_request_arbiter_if bus();

    dma_request_arbiter dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.Dreq           = '0;
        bus.Mask           = '0;
        bus.Mode           = 8'b01010101;
        bus.RotatePriority = 1'b0;
        bus.HLDA           = 1'b0;
        bus.ByteDone       = 1'b0;
        bus.TC             = 1'b0;
`ifdef DMA_SOFTWARE_REQUEST_EN
        bus.SwReq          = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_dack(input string tag);
        int i;
        i = 0;
        while (bus.ServiceValid !== 1'b1 && i < 20) begin
            step();
            i++;
        end
        check(tag, 32'(bus.ServiceValid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rot_exp = '{1, 3, 1, 3};
        do_reset();

        // reset values
        check("rst_hrq",    32'(bus.HRQ),          32'd0);
        check("rst_dack",   32'(bus.Dack),         32'd0);
        check("rst_active", 32'(bus.ActiveCh),     32'd0);
        check("rst_svc",    32'(bus.ServiceValid), 32'd0);
        check("rst_status", 32'(bus.Status),       32'd0);

        // single mode ch2, HLDA returned two cycles after HRQ
        bus.Dreq = 4'b0100;
        step();
        check("t1_hrq",      32'(bus.HRQ),    32'd1);
        check("t1_dack_req", 32'(bus.Dack),   32'd0);
        check("t1_status",   32'(bus.Status), 32'h4);
        step();
        check("t1_hrq_hold", 32'(bus.HRQ),    32'd1);
        check("t1_no_dack",  32'(bus.Dack),   32'd0);
        bus.HLDA = 1'b1;
        step();
        check("t1_dack",     32'(bus.Dack),         32'h4);
        check("t1_active",   32'(bus.ActiveCh),     32'd2);
        check("t1_svc",      32'(bus.ServiceValid), 32'd1);
        step();
        check("t1_dack_stable", 32'(bus.Dack), 32'h4);
        bus.ByteDone = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        check("t1_rel_hrq",  32'(bus.HRQ),          32'd0);
        check("t1_rel_dack", 32'(bus.Dack),         32'd0);
        check("t1_rel_svc",  32'(bus.ServiceValid), 32'd0);
        step();
        check("t1_idle_hrq", 32'(bus.HRQ), 32'd0);
        step();
        check("t1_rereq_hrq", 32'(bus.HRQ), 32'd1);
        step();
        check("t1_regrant", 32'(bus.Dack), 32'h4);
        bus.Dreq     = '0;
        bus.ByteDone = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        bus.HLDA     = 1'b0;
        step(2);
        check("t1_quiet", 32'(bus.HRQ), 32'd0);

        // fixed priority: lowest index wins
        do_reset();
        bus.Dreq = 4'b1010;
        bus.HLDA = 1'b1;
        wait_dack("t2_fixed_wait");
        check("t2_fixed_ch",   32'(bus.ActiveCh), 32'd1);
        check("t2_fixed_dack", 32'(bus.Dack),     32'h2);

        // rotating priority: order 1,3,1,3
        do_reset();
        bus.RotatePriority = 1'b1;
        bus.Dreq           = 4'b1010;
        bus.HLDA           = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_dack("t2_rot_wait");
            check("t2_rot_ch",   32'(bus.ActiveCh), 32'(rot_exp[t]));
            check("t2_rot_dack", 32'(bus.Dack),     32'd1 << rot_exp[t]);
            bus.ByteDone = 1'b1;
            step();
            bus.ByteDone = 1'b0;
        end

        // block mode ch0: holds until TC on byte 5
        do_reset();
        bus.Mode = 8'b01010110;
        bus.Dreq = 4'b0001;
        bus.HLDA = 1'b1;
        wait_dack("t3_wait");
        check("t3_dack", 32'(bus.Dack), 32'h1);
        bus.ByteDone = 1'b1;
        bus.Dreq     = '0;
        step();
        bus.ByteDone = 1'b0;
        check("t3_b1_hold", 32'(bus.Dack), 32'h1);
        bus.Mask = 4'b0001;
        for (int b = 2; b <= 4; b++) begin
            bus.ByteDone = 1'b1;
            step();
            bus.ByteDone = 1'b0;
            step();
            check("t3_bn_hold", 32'(bus.Dack), 32'h1);
        end
        bus.ByteDone = 1'b1;
        bus.TC       = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        bus.TC       = 1'b0;
        check("t3_tc_dack", 32'(bus.Dack), 32'd0);
        check("t3_tc_hrq",  32'(bus.HRQ),  32'd0);
        step(2);
        check("t3_idle_hrq", 32'(bus.HRQ), 32'd0);

        // demand mode ch2
        do_reset();
        bus.Mode = 8'b01000101;
        bus.Dreq = 4'b0100;
        bus.HLDA = 1'b1;
        wait_dack("t4_wait");
        check("t4_active", 32'(bus.ActiveCh), 32'd2);
        for (int b = 1; b <= 2; b++) begin
            bus.ByteDone = 1'b1;
            step();
            bus.ByteDone = 1'b0;
            check("t4_hold", 32'(bus.Dack), 32'h4);
        end
        bus.ByteDone = 1'b1;
        bus.Dreq     = '0;
        step();
        bus.ByteDone = 1'b0;
        check("t4_end", 32'(bus.Dack), 32'd0);
        step();
        bus.Dreq = 4'b0100;
        wait_dack("t4_wait2");
        bus.ByteDone = 1'b1;
        bus.TC       = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        bus.TC       = 1'b0;
        check("t4_tc_dack", 32'(bus.Dack),         32'd0);
        check("t4_tc_svc",  32'(bus.ServiceValid), 32'd0);

        // HLDA abort, REQ hold, reset during REQ, request withdrawal
        do_reset();
        bus.Dreq = 4'b0001;
        bus.HLDA = 1'b1;
        wait_dack("t5_wait");
        bus.HLDA = 1'b0;
        step();
        check("t5_abort_dack", 32'(bus.Dack),         32'd0);
        check("t5_abort_svc",  32'(bus.ServiceValid), 32'd0);
        check("t5_abort_hrq",  32'(bus.HRQ),          32'd0);
        step();
        check("t5_idle_hrq", 32'(bus.HRQ), 32'd0);
        step();
        check("t5_req_hrq", 32'(bus.HRQ), 32'd1);
        step(3);
        check("t5_req_wait_hrq",  32'(bus.HRQ),  32'd1);
        check("t5_req_wait_dack", 32'(bus.Dack), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_hrq",    32'(bus.HRQ),    32'd0);
        check("t5_rst_status", 32'(bus.Status), 32'd0);
        step();
        check("t5_rereq_hrq", 32'(bus.HRQ), 32'd1);
        bus.Dreq = '0;
        bus.HLDA = 1'b1;
        step();
        check("t5_withdraw_hrq",  32'(bus.HRQ),  32'd0);
        check("t5_withdraw_dack", 32'(bus.Dack), 32'd0);

        // masking and Status
        do_reset();
        bus.Dreq = 4'b0001;
        bus.Mask = 4'b0001;
        step(3);
        check("t6_masked_hrq",    32'(bus.HRQ),    32'd0);
        check("t6_masked_status", 32'(bus.Status), 32'd0);
        bus.Dreq = 4'b1011;
        step();
        check("t6_status", 32'(bus.Status), 32'hA);

`ifdef DMA_SOFTWARE_REQUEST_EN
        // software request on masked ch3, serviced as block
        do_reset();
        bus.Mask  = 4'b1000;
        bus.SwReq = 4'b1000;
        step();
        bus.SwReq = '0;
        check("t7_pending", 32'(bus.SwPending), 32'h8);
        bus.HLDA = 1'b1;
        wait_dack("t7_wait");
        check("t7_dack", 32'(bus.Dack), 32'h8);
        bus.ByteDone = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        check("t7_block_hold", 32'(bus.Dack), 32'h8);
        bus.ByteDone = 1'b1;
        bus.TC       = 1'b1;
        step();
        bus.ByteDone = 1'b0;
        bus.TC       = 1'b0;
        check("t7_tc_dack",    32'(bus.Dack),      32'd0);
        check("t7_pending_clr", 32'(bus.SwPending), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_request_arbiter.md
Name: dma_request_arbiter

Overview:
- Front-end arbitration stage of the 8237A model; sits directly upstream of the IO device array.
- Consumes per-channel Dreq from the IO devices, runs the HRQ/HLDA bus handshake with the processor, and drives the one-hot Dack that tells a device to use nIOR/nIOW.
- Tells the transfer timing engine which channel owns the bus. Ends service on per-byte completion or terminal count, according to the channel mode.

Parameters:
- NUM_CH, default 4: number of DMA channels. Fixed at 4 for 8237A compatibility.
- CH_W, default 2: width of a channel index; equals clog2(NUM_CH).

Ports:
- Clock  input  1  system clock; all state changes on its rising edge
- Reset  input  1  synchronous, active-high reset
- Dreq  input  NUM_CH  device DMA requests, active high, level sensitive
- Mask  input  NUM_CH  per-channel mask from mask register; 1 = ignore Dreq
- Mode  input  2*NUM_CH  per-channel mode; 2'b00 demand, 2'b01 single, 2'b10 block, 2'b11 treated as single
- RotatePriority  input  1  0 = fixed priority (ch0 highest), 1 = rotating priority
- HLDA  input  1  hold acknowledge from processor
- ByteDone  input  1  one-cycle pulse from timing engine: one transfer completed on the active channel
- TC  input  1  one-cycle pulse: terminal count reached on the active channel
- HRQ  output  1  hold request to processor
- Dack  output  NUM_CH  one-hot DMA acknowledge to devices
- ActiveCh  output  CH_W  index of the channel being serviced
- ServiceValid  output  1  high while Dack is asserted; enables the timing engine
- Status  output  NUM_CH  registered pending requests, equal to Dreq & ~Mask

Behaviour:
- Reset values: HRQ=0, Dack=0, ActiveCh=0, ServiceValid=0, Status=0, priority pointer=0, state=IDLE.
  - Reset in any state returns to IDLE on the next edge and drops Dack and HRQ in that same edge.
- Eligible request set: E = Dreq & ~Mask, sampled each cycle and registered into Status.
- States: IDLE, REQ, SERVICE, RELEASE.
- IDLE:
  - If E != 0 at edge N, go to REQ and assert HRQ from cycle N+1.
- REQ:
  - Hold HRQ=1.
  - When HLDA=1 at an edge, re-resolve the winner from the current E.
    - If E != 0: latch the winner into ActiveCh; set Dack[winner]=1 and ServiceValid=1 on the next cycle; go to SERVICE.
    - If E == 0 (request withdrawn): go to RELEASE.
  - HLDA=0: remain in REQ indefinitely.
- Priority:
  - Fixed: lowest index wins.
  - Rotating: search starts at the pointer and wraps modulo NUM_CH. On leaving SERVICE, pointer = ActiveCh+1 mod NUM_CH, making the just-serviced channel lowest priority. Example: pointer at 3 checks 3,0,1,2.
- SERVICE: Dack and ActiveCh stay stable. The first matching exit rule below applies; any of them goes to RELEASE.
  - HLDA drops to 0: abort.
  - TC=1: ends service in all modes. TC together with ByteDone is treated as TC.
  - Single mode: ByteDone=1.
  - Demand mode: ByteDone=1 while Dreq[ActiveCh]=0 in the same cycle.
  - Block mode: ignores Dreq and Mask changes until TC.
- Mask or Dreq changes during SERVICE never preempt the active channel mid-byte.
- RELEASE:
  - Exactly one cycle with HRQ=0, Dack=0, ServiceValid=0, then IDLE.
  - This guarantees the processor one bus-free cycle between grants. Back-to-back requests therefore need at least 3 cycles from RELEASE to the next Dack.
- Dack is never multi-hot. Dack is never asserted unless HLDA was 1 at the preceding edge.

Optional Feature:
- Macro DMA_SOFTWARE_REQUEST_EN.
- When defined:
  - Add input SwReq (NUM_CH) and output SwPending (NUM_CH).
  - A SwReq pulse sets a sticky pending bit. The eligible set becomes E = (Dreq & ~Mask) | SwPending; software requests ignore Mask.
  - A pending bit clears on TC while its channel is active, or on Reset.
  - Software-requested channels are always serviced in block mode regardless of Mode.
- When undefined: no extra ports; behaviour exactly as above.

Decomposition:
- Package dma_pkg holds:
  - typedef enum arb_state_t {IDLE, REQ, SERVICE, RELEASE};
  - typedef enum logic [1:0] dma_mode_t {DEMAND, SINGLE, BLOCK, CASCADE_RSVD};
  - constants NUM_CH and CH_W.
- Sub-module dma_priority_resolver: combinational. Takes E, pointer and RotatePriority; returns winner index and a valid flag. Reused by the later command-register model.

Test Plan:
- Dreq=4'b0100, Mode single, HLDA returned 2 cycles after HRQ: HRQ at N+1, Dack=4'b0100 one cycle after HLDA, one ByteDone, then RELEASE with HRQ=0 for 1 cycle and re-request while Dreq is held.
- Dreq=4'b1010, fixed priority: ch1 served first. With RotatePriority=1 and 4 single transfers: service order 1,3,1,3 and pointer values 2,0,2,0.
- Block mode ch0, Dreq dropped after first byte: Dack held until the TC pulse on byte 5, then RELEASE.
- Demand mode ch2: Dreq cleared in the same cycle as the third ByteDone ends service. A TC coincident with ByteDone ends it regardless of Dreq.
- HLDA deasserted mid-SERVICE: Dack=0 and ServiceValid=0 next cycle, one RELEASE cycle. Reset asserted during REQ: HRQ=0 the following cycle, Status=0.
- With DMA_SOFTWARE_REQUEST_EN: SwReq[3] pulse with Mask=4'b1000 gives Dack[3], block transfer until TC, then SwPending[3] clears.
